// File: rtl/gbuff_feeder_pkg.sv
// Shared buffer/array defines (single include guard) and the feeder's FSM state type.
// Compiled first so every later file sees the defines and the package.
`ifndef DEFINE_V
`define DEFINE_V
`define DATA_SIZE        8
`define ARRAY_SIZE       4
`define WORD_SIZE        32
`define GBUFF_INDX_SIZE  8
`define ST_IDLE          2'd0
`define ST_READ          2'd1
`define ST_DRAIN         2'd2
`define ST_DONE          2'd3
`endif

package gbuff_feeder_pkg;
  typedef enum logic [1:0] {
    IDLE  = `ST_IDLE,
    READ  = `ST_READ,
    DRAIN = `ST_DRAIN,
    DONE  = `ST_DONE
  } state_e;

  localparam int INDX_W = `GBUFF_INDX_SIZE;
endpackage

// File: rtl/skew_shift_reg.sv
// Fixed-depth delay line with synchronous clear; zeros enter from reset so no stale data leaks out.
module skew_shift_reg #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];
endmodule

// File: rtl/gbuff_feeder.sv
// Streams K words from the global buffer into the array's west edge, skewing lane r by r cycles.
// feed_valid qualifies feed_data; there is no backpressure, the array must accept every valid cycle.
module gbuff_feeder
  import gbuff_feeder_pkg::*;
#(
  parameter int ARRAY_SIZE = `ARRAY_SIZE,
  parameter int DATA_SIZE  = `DATA_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [`GBUFF_INDX_SIZE-1:0]      base_index,
  input  logic [`GBUFF_INDX_SIZE-1:0]      k_len,
  output logic                             gbuff_wr_en,
  output logic [`GBUFF_INDX_SIZE-1:0]      gbuff_index,
  input  logic [`WORD_SIZE-1:0]            gbuff_data,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0]  feed_data,
  output logic                             feed_valid,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       dbg_state
);
  localparam int FW = ARRAY_SIZE * DATA_SIZE;
  localparam int VP = ARRAY_SIZE - 1;

  state_e                      state_q, state_d;
  logic [`GBUFF_INDX_SIZE-1:0] idx_q, idx_d;
  logic [`GBUFF_INDX_SIZE-1:0] cnt_q, cnt_d;
  logic [`GBUFF_INDX_SIZE-1:0] k_q, k_d;
  logic                        rd_vld_q, rd_vld_d;
  logic [VP-1:0]               vld_pipe_q, vld_pipe_d;

  // rd_vld_q marks the cycle a requested word is on gbuff_data; vld_pipe_q tracks it down the skew.
  assign rd_vld_d   = (state_q == READ);
  assign vld_pipe_d = (vld_pipe_q << 1) | VP'(rd_vld_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_d = READ;
            idx_d   = base_index;
            k_d     = k_len;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (cnt_q == k_q - 1'b1) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Leave once nothing will be valid next cycle: the last element has left the deepest lane.
      DRAIN: if (vld_pipe_d == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      rd_vld_q   <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      rd_vld_q   <= rd_vld_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Lane 0 has zero skew, so it is the buffer's registered output gated by the word-valid flag.
  assign feed_data[FW-1 -: DATA_SIZE] =
    rd_vld_q ? gbuff_data[`WORD_SIZE-1 -: DATA_SIZE] : '0;

  for (genvar r = 1; r < ARRAY_SIZE; r++) begin : g_lane
    logic [DATA_SIZE-1:0] lane_elem;
    assign lane_elem = rd_vld_q ? gbuff_data[`WORD_SIZE-1-r*DATA_SIZE -: DATA_SIZE] : '0;
    skew_shift_reg #(
      .DEPTH (r),
      .WIDTH (DATA_SIZE)
    ) u_skew (
      .clk_i  (clk),
      .clr_i  (rst),
      .din_i  (lane_elem),
      .dout_o (feed_data[FW-1-r*DATA_SIZE -: DATA_SIZE])
    );
  end

  assign gbuff_wr_en = 1'b0;
  assign gbuff_index = idx_q;
  assign feed_valid  = rd_vld_q | (|vld_pipe_q);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_gbuff_feeder.sv
// Bench for gbuff_feeder: cycle-indexed expectation tables built from the transfer timing rules,
// a per-cycle compare process, and literal checks on the observed history.
module tb_gbuff_feeder;
  import gbuff_feeder_pkg::*;

  localparam int A    = 4;
  localparam int NCYC = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_index;
  logic [7:0]  k_len;
  logic        gbuff_wr_en;
  logic [7:0]  gbuff_index;
  logic [31:0] gbuff_data;
  logic [31:0] feed_data;
  logic        feed_valid;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  gbuff_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_index  (base_index),
    .k_len       (k_len),
    .gbuff_wr_en (gbuff_wr_en),
    .gbuff_index (gbuff_index),
    .gbuff_data  (gbuff_data),
    .feed_data   (feed_data),
    .feed_valid  (feed_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter / buffer model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] mem [256];
  always @(posedge clk) gbuff_data <= mem[gbuff_index];

  // ---------------- expectation tables and observed history ----------------
  bit [31:0] exp_feed  [NCYC];
  bit        exp_valid [NCYC];
  bit        exp_busy  [NCYC];
  bit        exp_done  [NCYC];
  bit [7:0]  exp_idx   [NCYC];

  logic [31:0] obs_feed  [NCYC];
  logic        obs_valid [NCYC];
  logic        obs_busy  [NCYC];
  logic        obs_done  [NCYC];
  logic [7:0]  obs_idx   [NCYC];
  logic [1:0]  obs_state [NCYC];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Transfer accepted at cycle c0: index base+j in c0+1+j, lane r of word j in c0+2+j+r,
  // valid c0+2..c0+K+A, busy c0+1..done, done at c0+K+A+1 (c0+1 when K=0).
  task automatic schedule(int c0, logic [7:0] base, int k);
    int last;
    logic [31:0] w;
    last = (k == 0) ? c0 + 1 : c0 + k + A + 1;
    for (int c = c0 + 1; c <= last; c++) exp_busy[c] = 1'b1;
    exp_done[last] = 1'b1;
    for (int j = 0; j < k; j++) begin
      w = mem[8'(base + j)];
      exp_idx[c0 + 1 + j] = 8'(base + j);
      for (int r = 0; r < A; r++)
        exp_feed[c0 + 2 + j + r][31 - 8*r -: 8] = w[31 - 8*r -: 8];
    end
    if (k > 0) begin
      for (int c = c0 + k; c < NCYC; c++) exp_idx[c] = 8'(base + k - 1);
      for (int c = c0 + 2; c <= c0 + k + A; c++) exp_valid[c] = 1'b1;
    end
  endtask

  task automatic model_reset(int from);
    for (int c = from; c < NCYC; c++) begin
      exp_feed[c]  = '0;
      exp_valid[c] = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_done[c]  = 1'b0;
      exp_idx[c]   = '0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      obs_feed[cyc]  = feed_data;
      obs_valid[cyc] = feed_valid;
      obs_busy[cyc]  = busy;
      obs_done[cyc]  = done;
      obs_idx[cyc]   = gbuff_index;
      obs_state[cyc] = dbg_state;
      n_total++;
      if (feed_data === exp_feed[cyc] && feed_valid === exp_valid[cyc] &&
          busy === exp_busy[cyc] && done === exp_done[cyc] &&
          gbuff_index === exp_idx[cyc] && gbuff_wr_en === 1'b0 &&
          (exp_busy[cyc] || dbg_state === 2'(IDLE)))
        n_pass++;
      else
        $display("FAIL cycle %0d: feed=%h/%h valid=%b/%b busy=%b/%b done=%b/%b idx=%h/%h wr_en=%b/0 state=%0d (got/required)",
                 cyc, feed_data, exp_feed[cyc], feed_valid, exp_valid[cyc], busy, exp_busy[cyc],
                 done, exp_done[cyc], gbuff_index, exp_idx[cyc], gbuff_wr_en, dbg_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [7:0] base, logic [7:0] k);
    start      = 1'b1;
    base_index = base;
    k_len      = k;
    if (!exp_busy[cyc]) schedule(cyc, base, int'(k));
    tick();
    start      = 1'b0;
    base_index = 8'hEE;
    k_len      = 8'h05;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    model_reset(cyc + 1);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c, c2, nd;
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i), 8'(i ^ 8'h3C), 8'(255 - i), 8'(i + 7)};
    mem[0]   = 32'h01020304;
    mem[1]   = 32'h05060708;
    mem[2]   = 32'h090A0B0C;
    mem[3]   = 32'h0D0E0F10;
    mem[254] = 32'hAABBCCDD;
    mem[255] = 32'h11223344;
    model_reset(0);

    rst = 1'b1; start = 1'b0; base_index = '0; k_len = '0;
    repeat (3) tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("reset_feed",  obs_feed[cyc-1],  32'h0);
    chk("reset_busy",  {31'b0, obs_busy[cyc-1]}, 32'h0);
    chk("reset_idx",   {24'b0, obs_idx[cyc-1]},  32'h0);
    chk("reset_state", {30'b0, obs_state[cyc-1]}, 32'(IDLE));

    // Basic stream
    c = cyc;
    do_start(8'd0, 8'd4);
    repeat (9) tick();
    chk("basic_lane0_c2", {24'b0, obs_feed[c+2][31:24]}, 32'h01);
    chk("basic_lane0_c5", {24'b0, obs_feed[c+5][31:24]}, 32'h0D);
    chk("basic_lane3_c5", {24'b0, obs_feed[c+5][7:0]},   32'h04);
    chk("basic_lane3_c8", {24'b0, obs_feed[c+8][7:0]},   32'h10);
    chk("basic_c8_lanes", obs_feed[c+8], 32'h00000010);
    chk("basic_c9_zero",  obs_feed[c+9], 32'h0);
    chk("basic_valid_c2", {31'b0, obs_valid[c+2]}, 32'h1);
    chk("basic_valid_c8", {31'b0, obs_valid[c+8]}, 32'h1);
    chk("basic_valid_c9", {31'b0, obs_valid[c+9]}, 32'h0);
    chk("basic_done_c9",  {31'b0, obs_done[c+9]},  32'h1);

    // Back-to-back: start in the cycle right after done
    c = cyc;
    do_start(8'd0, 8'd4);
    repeat (9) tick();
    chk("b2b_lane0_c2", {24'b0, obs_feed[c+2][31:24]}, 32'h01);
    chk("b2b_valid_c1", {31'b0, obs_valid[c+1]}, 32'h0);
    chk("b2b_done_c9",  {31'b0, obs_done[c+9]},  32'h1);

    // Index wrap
    c = cyc;
    do_start(8'd254, 8'd4);
    repeat (9) tick();
    chk("wrap_idx_c1", {24'b0, obs_idx[c+1]}, 32'hFE);
    chk("wrap_idx_c2", {24'b0, obs_idx[c+2]}, 32'hFF);
    chk("wrap_idx_c3", {24'b0, obs_idx[c+3]}, 32'h00);
    chk("wrap_idx_c4", {24'b0, obs_idx[c+4]}, 32'h01);
    chk("wrap_lane0_c2", {24'b0, obs_feed[c+2][31:24]}, 32'hAA);
    chk("wrap_lane3_c6", {24'b0, obs_feed[c+6][7:0]},   32'h44);

    // Zero length
    c = cyc;
    do_start(8'd5, 8'd0);
    repeat (2) tick();
    chk("zero_done_c1",  {31'b0, obs_done[c+1]},  32'h1);
    chk("zero_busy_c1",  {31'b0, obs_busy[c+1]},  32'h1);
    chk("zero_busy_c2",  {31'b0, obs_busy[c+2]},  32'h0);
    chk("zero_valid_c1", {31'b0, obs_valid[c+1]}, 32'h0);
    chk("zero_idx_c1",   {24'b0, obs_idx[c+1]},   32'h01);

    // Start while busy is ignored
    c = cyc;
    do_start(8'd0, 8'd4);
    repeat (2) tick();
    do_start(8'd8, 8'd4);
    repeat (6) tick();
    nd = 0;
    for (int i = c + 1; i <= c + 9; i++) nd += int'(obs_done[i]);
    chk("busy_start_one_done", 32'(nd), 32'd1);
    chk("busy_start_idx_c4", {24'b0, obs_idx[c+4]}, 32'h03);
    chk("busy_start_idx_c6", {24'b0, obs_idx[c+6]}, 32'h03);

    // Reset mid-run, then a fresh transfer
    c = cyc;
    do_start(8'd0, 8'd4);
    repeat (3) tick();
    do_rst();
    tick();
    chk("rst_feed",  obs_feed[c+5], 32'h0);
    chk("rst_valid", {31'b0, obs_valid[c+5]}, 32'h0);
    chk("rst_busy",  {31'b0, obs_busy[c+5]},  32'h0);
    chk("rst_idx",   {24'b0, obs_idx[c+5]},   32'h0);
    chk("rst_state", {30'b0, obs_state[c+5]}, 32'(IDLE));
    repeat (6) tick();
    nd = 0;
    for (int i = c + 5; i <= c + 11; i++) nd += int'(obs_done[i]);
    chk("rst_no_done", 32'(nd), 32'd0);
    c2 = cyc;
    do_start(8'd0, 8'd4);
    repeat (10) tick();
    chk("fresh_lane3_c5", {24'b0, obs_feed[c2+5][7:0]}, 32'h04);
    chk("fresh_done_c9",  {31'b0, obs_done[c2+9]},     32'h1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
